pcpi_initiator: RTL and testbench
=================================

// Module: pcpi_initiator
// PURPOSE
//  Initiator (core-side) end of the PCPI co-processor interface. Accepts one
//  command (insn, rs1, rs2) on a valid/ready port and drives the PCPI request.
//  It waits for pcpi_ready, applying the PicoRV32 timeout/pcpi_wait rule, and
//  returns rd, wr and a trap flag on a valid/ready response port.
//  Sits between a command source (core model, DMA, test sequencer) and one or
//  more PCPI responders, e.g. picorv32_pcpi_fpadd.
// PARAMETERS
//  TIMEOUT_CYCLES  16  no-ready/no-wait cycles before the op traps (2..255)
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  cmd_valid     in   1   command offered
//  cmd_ready     out  1   command accepted when both cmd_valid and cmd_ready are high
//  cmd_insn      in   32  instruction word (e.g. custom-0 0x0000000B | rd/rs fields)
//  cmd_rs1       in   32  operand 1
//  cmd_rs2       in   32  operand 2
//  rsp_valid     out  1   response available
//  rsp_ready     in   1   response consumed when both rsp_valid and rsp_ready are high
//  rsp_rd        out  32  result (0 on trap)
//  rsp_wr        out  1   responder requested writeback (0 on trap)
//  rsp_trap      out  1   no responder claimed insn (timeout)
//  pcpi_valid    out  1   PCPI request strobe
//  pcpi_insn     out  32  latched cmd_insn
//  pcpi_rs1      out  32  latched cmd_rs1
//  pcpi_rs2      out  32  latched cmd_rs2
//  pcpi_wr       in   1   responder write-enable
//  pcpi_rd       in   32  responder result
//  pcpi_wait     in   1   responder busy (multi-cycle op)
//  pcpi_ready    in   1   responder done
// BEHAVIOUR
//  - Reset values:
//    - Zero: pcpi_valid, rsp_valid, rsp_wr, rsp_trap, pcpi_insn/rs1/rs2, rsp_rd.
//    - cmd_ready=1. FSM state=IDLE. Counter=0.
//  - IDLE: cmd_ready=1.
//    - On accept: latch insn/rs1/rs2, counter=0, go REQ.
//    - pcpi_valid rises on the cycle after accept.
//  - REQ: cmd_ready=0. pcpi_valid=1 and pcpi_* operands are held stable.
//    - First REQ cycle (issue): pcpi_ready and pcpi_wait are ignored. Responders
//      may still show ready from the previous op.
//    - Later cycles, with pcpi_ready=1: capture rd=pcpi_rd and wr=pcpi_wr, set
//      trap=0, and go RSP. pcpi_valid is 0 on the next cycle.
//    - Later cycles, with pcpi_wait=1 and no ready: clear the counter and stay in REQ.
//    - Otherwise: increment the counter. On the cycle it reaches TIMEOUT_CYCLES,
//      set trap=1, rd=0, wr=0 and go RSP.
//    - If ready and timeout occur in the same cycle, ready wins.
//  - RSP: rsp_valid=1 with rsp_* stable until rsp_ready. On that cycle go IDLE.
//    - cmd_ready rises on the next cycle. There is no command/response overlap.
//  - Minimum latency, accept to rsp_valid: 3 cycles (accept, issue, ready).
//  - Asserting reset mid-op aborts immediately: pcpi_valid drops asynchronously
//    and no response is produced.
// CONFIGURATION
//  - `PCPI_INIT_LATENCY_EN` defined:
//    - Adds output rsp_cycles[15:0]: count of cycles pcpi_valid was high for
//      this op (issue cycle = 1), saturating at 16'hFFFF.
//    - Valid with rsp_valid. Reset value 0.
//  - Undefined: the port and its counter are absent. Behaviour is otherwise identical.
// STRUCTURE
//  - Package pcpi_pkg holds:
//    - state enum {IDLE, REQ, RSP}
//    - PCPI_OPC_CUSTOM0=7'b0001011 and PCPI_F7_FPADD=7'b0000000
//    - PCPI_INSN_W=32 and PCPI_XLEN=32
//  - Sub-module pcpi_timeout_ctr(clk, reset, clr, inc, hit) with parameter
//    LIMIT=TIMEOUT_CYCLES. It is an 8-bit counter; hit is combinational at
//    count==LIMIT-1 with inc=1.
// TESTING
//  - FPADD with fpadd responder: insn 0x0000000B, rs1 0x3F800000, rs2 0x40000000
//    -> rsp_rd 0x40400000, wr=1, trap=0.
//  - Inf plus -Inf: rs1 0x7F800000, rs2 0xFF800000 -> rsp_rd 0xFFC00000, trap=0.
//    pcpi_wait is high throughout, so no timeout.
//  - Unclaimed insn 0x00000033, no responder (wait=ready=0) -> rsp_trap=1, rd=0,
//    wr=0. rsp_valid rises exactly TIMEOUT_CYCLES+2 cycles after accept.
//  - Stale ready: responder holds pcpi_ready=1 on the issue cycle, then wait for
//    8 cycles -> ready is ignored on issue and the result is taken from the
//    later ready.
//  - Backpressure: rsp_ready low for 5 cycles -> rsp_* stable, cmd_ready=0, and
//    pcpi_valid=0 throughout.
//  - Reset after 3 REQ cycles -> pcpi_valid=0 and rsp_valid=0 at once, cmd_ready=1.
//    The next command then completes normally.

Source files
------------

// File: rtl/pcpi_initiator_pkg.sv
// Shared types and constants for the PCPI initiator slice.
// Optional feature macro used by this slice: PCPI_INIT_LATENCY_EN.
package pcpi_pkg;

   localparam int PCPI_INSN_W = 32;
   localparam int PCPI_XLEN   = 32;

   localparam logic [6:0] PCPI_OPC_CUSTOM0 = 7'b0001011;
   localparam logic [6:0] PCPI_F7_FPADD    = 7'b0000000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP
   } pcpi_state_t;

endpackage

// File: rtl/pcpi_initiator_if.sv
// Command, response and PCPI bus bundle for the initiator.
// rsp_cycles exists only when PCPI_INIT_LATENCY_EN is defined.
interface pcpi_initiator_if;
   import pcpi_pkg::*;

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [PCPI_INSN_W-1:0] cmd_insn;
   logic [PCPI_XLEN-1:0]   cmd_rs1;
   logic [PCPI_XLEN-1:0]   cmd_rs2;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [PCPI_XLEN-1:0]   rsp_rd;
   logic                   rsp_wr;
   logic                   rsp_trap;
`ifdef PCPI_INIT_LATENCY_EN
   logic [15:0]            rsp_cycles;
`endif

   logic                   pcpi_valid;
   logic [PCPI_INSN_W-1:0] pcpi_insn;
   logic [PCPI_XLEN-1:0]   pcpi_rs1;
   logic [PCPI_XLEN-1:0]   pcpi_rs2;
   logic                   pcpi_wr;
   logic [PCPI_XLEN-1:0]   pcpi_rd;
   logic                   pcpi_wait;
   logic                   pcpi_ready;

   modport master (
      input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2, rsp_ready,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
`ifdef PCPI_INIT_LATENCY_EN
      output rsp_cycles,
`endif
      output cmd_ready, rsp_valid, rsp_rd, rsp_wr, rsp_trap,
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
   );

   modport slave (
      output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2, rsp_ready,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
`ifdef PCPI_INIT_LATENCY_EN
      input  rsp_cycles,
`endif
      input  cmd_ready, rsp_valid, rsp_rd, rsp_wr, rsp_trap,
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
   );

endinterface

// File: rtl/pcpi_initiator_timeout_ctr.sv
// 8-bit no-progress counter; hit flags the increment that would reach LIMIT.
module pcpi_timeout_ctr #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= count + 8'd1;
   end

   assign hit = inc && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/pcpi_initiator.sv
// Core-side PCPI initiator: one command in, one PCPI request out, one response back.
// Define PCPI_INIT_LATENCY_EN to add the rsp_cycles latency counter.
module pcpi_initiator
   import pcpi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pcpi_initiator_if.master     bus
);

   pcpi_state_t state;
   logic        issue;
   logic        claim;
   logic        stall;
   logic        tick;
   logic        hit;

   // The issue cycle ignores ready/wait: a responder may still show ready from the last op.
   assign claim = (state == REQ) && !issue && bus.pcpi_ready;
   assign stall = (state == REQ) && !issue && !bus.pcpi_ready && bus.pcpi_wait;
   assign tick  = (state == REQ) && !issue && !bus.pcpi_ready && !bus.pcpi_wait;

   pcpi_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clr   (((state == IDLE) && bus.cmd_valid) || stall),
      .inc   (tick),
      .hit   (hit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         issue          <= 1'b0;
         bus.cmd_ready  <= 1'b1;
         bus.pcpi_valid <= 1'b0;
         bus.pcpi_insn  <= '0;
         bus.pcpi_rs1   <= '0;
         bus.pcpi_rs2   <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_rd     <= '0;
         bus.rsp_wr     <= 1'b0;
         bus.rsp_trap   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.pcpi_insn  <= bus.cmd_insn;
                  bus.pcpi_rs1   <= bus.cmd_rs1;
                  bus.pcpi_rs2   <= bus.cmd_rs2;
                  bus.pcpi_valid <= 1'b1;
                  bus.cmd_ready  <= 1'b0;
                  issue          <= 1'b1;
                  state          <= REQ;
               end
            end
            REQ: begin
               issue <= 1'b0;
               // Ready beats a timeout landing on the same cycle.
               if (claim || hit) begin
                  bus.rsp_rd     <= claim ? bus.pcpi_rd : '0;
                  bus.rsp_wr     <= claim && bus.pcpi_wr;
                  bus.rsp_trap   <= !claim;
                  bus.pcpi_valid <= 1'b0;
                  bus.rsp_valid  <= 1'b1;
                  state          <= RSP;
               end
            end
            RSP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PCPI_INIT_LATENCY_EN
   logic [15:0] cycles_q;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Counts pcpi_valid-high cycles; the issue cycle is preloaded as 1 on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cycles_q <= '0;
      else if ((state == IDLE) && bus.cmd_valid)
         cycles_q <= 16'd1;
      else if ((state == REQ) && !claim && !hit)
         cycles_q <= sat_inc16(cycles_q);
   end

   assign bus.rsp_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
// Randomized bench for pcpi_initiator with a cycle-indexed behavioural model.
// Builds with or without PCPI_INIT_LATENCY_EN.
module tb_pcpi_initiator;
   import pcpi_pkg::*;

   localparam int T = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pcpi_initiator_if bus();

   pcpi_initiator #(.TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model of the op in flight, indexed by cycle c relative to the accept cycle (c=0).
   bit          m_active = 1'b0;
   int          m_c = 0, m_L = 0, m_D = 0;
   logic [31:0] e_insn, e_rs1, e_rs2, e_rd;
   logic        e_wr, e_trap;

   bit          pin_en = 1'b0;
   int          pin_L = 0;
   logic [31:0] pin_rd;
   logic        pin_trap;

   bit          seen;
   int          obs_L;
   logic [31:0] obs_rd;
   logic        obs_trap;
   logic        ecr, epv, erv;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
         chk("rst_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_rsp_rd", bus.rsp_rd, 32'd0);
         chk("rst_rsp_flags", {30'd0, bus.rsp_wr, bus.rsp_trap}, 32'd0);
         chk("rst_pcpi_ops", bus.pcpi_insn | bus.pcpi_rs1 | bus.pcpi_rs2, 32'd0);
      end else begin
         if (!m_active || m_c == 0) begin
            ecr = 1'b1; epv = 1'b0; erv = 1'b0;
         end else if (m_c < m_L) begin
            ecr = 1'b0; epv = 1'b1; erv = 1'b0;
         end else begin
            ecr = 1'b0; epv = 1'b0; erv = 1'b1;
         end
         chk("cmd_ready", 32'(bus.cmd_ready), 32'(ecr));
         chk("pcpi_valid", 32'(bus.pcpi_valid), 32'(epv));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(erv));
         if (epv) begin
            chk("pcpi_insn", bus.pcpi_insn, e_insn);
            chk("pcpi_rs1", bus.pcpi_rs1, e_rs1);
            chk("pcpi_rs2", bus.pcpi_rs2, e_rs2);
         end
         if (erv) begin
            chk("rsp_rd", bus.rsp_rd, e_rd);
            chk("rsp_wr", 32'(bus.rsp_wr), 32'(e_wr));
            chk("rsp_trap", 32'(bus.rsp_trap), 32'(e_trap));
`ifdef PCPI_INIT_LATENCY_EN
            chk("rsp_cycles", 32'(bus.rsp_cycles), 32'(m_L - 1));
`endif
         end
         if (m_active && m_c == 0) begin
            seen = 1'b0; obs_L = -1; obs_rd = 32'hDEADBEEF; obs_trap = 1'bx;
         end
         if (m_active && bus.rsp_valid && !seen) begin
            seen = 1'b1; obs_L = m_c; obs_rd = bus.rsp_rd; obs_trap = bus.rsp_trap;
         end
         if (m_active && pin_en && m_c == m_D) begin
            chk("lit_latency", 32'(obs_L), 32'(pin_L));
            chk("lit_rd", obs_rd, pin_rd);
            chk("lit_trap", 32'(obs_trap), 32'(pin_trap));
         end
      end
   end

   task automatic idle_cycle();
      bus.cmd_valid  = 1'b0;
      bus.rsp_ready  = 1'($urandom);
      bus.pcpi_ready = 1'($urandom);
      bus.pcpi_wait  = 1'($urandom);
      bus.pcpi_rd    = $urandom;
      bus.pcpi_wr    = 1'($urandom);
      @(posedge clk); #1;
   endtask

   // W: cycles of pcpi_wait after issue; G: silent cycles after that before ready
   // (G >= T means the responder never answers); B: rsp_ready backpressure cycles.
   task automatic run_op(input logic [31:0] insn, rs1, rs2, res, input logic wr,
                         input bit stale, input int W, G, B, abort_c,
                         input bit pe, input int pl, input logic [31:0] prd, input logic ptr);
      int L;
      L = (G < T) ? (W + G + 3) : (W + T + 2);
      e_insn = insn; e_rs1 = rs1; e_rs2 = rs2;
      e_trap = (G >= T);
      e_rd   = e_trap ? 32'd0 : res;
      e_wr   = e_trap ? 1'b0 : wr;
      m_L = L; m_D = L + B;
      pin_en = pe; pin_L = pl; pin_rd = prd; pin_trap = ptr;
      m_active = 1'b1;
      for (int c = 0; c <= L + B; c++) begin
         m_c = c;
         if (c == abort_c) begin
            reset = 1'b1;
            m_active = 1'b0;
            bus.cmd_valid = 1'b0;
            break;
         end
         bus.cmd_valid = (c == 0) ? 1'b1 : ((c < L + B) ? 1'($urandom) : 1'b0);
         bus.cmd_insn  = (c == 0) ? insn : $urandom;
         bus.cmd_rs1   = (c == 0) ? rs1 : $urandom;
         bus.cmd_rs2   = (c == 0) ? rs2 : $urandom;
         bus.rsp_ready = (c == L + B) ? 1'b1 : ((c >= L) ? 1'b0 : 1'($urandom));
         bus.pcpi_ready = 1'b0;
         bus.pcpi_wait  = 1'($urandom);
         bus.pcpi_rd    = $urandom;
         bus.pcpi_wr    = 1'($urandom);
         if (c == 0 || c >= L) bus.pcpi_ready = 1'($urandom);
         else if (c == 1) bus.pcpi_ready = stale;
         else if (c <= W + 1) bus.pcpi_wait = 1'b1;
         else if (c <= W + G + 1) bus.pcpi_wait = 1'b0;
         else if (c == W + G + 2 && G < T) begin
            bus.pcpi_ready = 1'b1;
            bus.pcpi_rd    = res;
            bus.pcpi_wr    = wr;
         end
         @(posedge clk); #1;
      end
      m_active = 1'b0;
      pin_en = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_insn = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
      bus.rsp_ready = 1'b0; bus.pcpi_ready = 1'b0; bus.pcpi_wait = 1'b0;
      bus.pcpi_rd = '0; bus.pcpi_wr = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      idle_cycle();

      run_op(32'h0000000B, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 1'b0,
             0, 0, 0, -1, 1'b1, 3, 32'h40400000, 1'b0);
      run_op(32'h0000000B, 32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b1, 1'b0,
             20, 0, 0, -1, 1'b1, 23, 32'hFFC00000, 1'b0);
      run_op(32'h00000033, 32'h12345678, 32'h9ABCDEF0, 32'h55555555, 1'b1, 1'b0,
             0, 100, 0, -1, 1'b1, 18, 32'h00000000, 1'b1);
      idle_cycle();
      run_op(32'h0000000B, 32'h00000001, 32'h00000002, 32'hCAFEF00D, 1'b1, 1'b1,
             8, 0, 0, -1, 1'b1, 11, 32'hCAFEF00D, 1'b0);
      run_op(32'h0000000B, 32'hAAAA0000, 32'h0000BBBB, 32'hA5A5A5A5, 1'b0, 1'b0,
             1, 2, 5, -1, 1'b1, 6, 32'hA5A5A5A5, 1'b0);
      run_op(32'h0000000B, 32'h1, 32'h2, 32'h0BADF00D, 1'b1, 1'b0,
             0, T - 1, 1, -1, 1'b1, 18, 32'h0BADF00D, 1'b0);
      run_op(32'h0000000B, 32'h3, 32'h4, 32'h0BADF00D, 1'b1, 1'b0,
             0, T, 2, -1, 1'b1, 18, 32'h00000000, 1'b1);

      run_op(32'h0000000B, 32'h5, 32'h6, 32'h77777777, 1'b1, 1'b0,
             0, 100, 0, 4, 1'b0, 0, 32'h0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      run_op(32'h0200000B, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 1'b0,
             2, 1, 0, -1, 1'b1, 6, 32'h33333333, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] ri, r1, r2;
         int w, g;
         ri = $urandom; r1 = $urandom; r2 = $urandom;
         w = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 5));
         g = int'($urandom_range(0, T + 2));
         run_op(ri, r1, r2, (r1 + r2) ^ ri, 1'($urandom), 1'($urandom),
                w, g, int'($urandom_range(0, 3)), -1, 1'b0, 0, 32'h0, 1'b0);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      idle_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
